// File: rtl/mw_writeback.sv
// Writeback stage: decodes the MEM/WB instruction and arbitrates the single register-file
// write port between the pipeline and a 2-entry multdiv pending-write buffer.
module mw_writeback #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] o_in,
    input  logic [31:0] d_in,
    input  logic [31:0] ir_in,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_result,
    output logic        md_ready,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        stall_out,
    output logic [1:0]  pend_count,
    output logic [4:0]  pend_rd0,
    output logic [4:0]  pend_rd1
);

    typedef enum logic [1:0] {SRC_NONE, SRC_HEAD, SRC_PIPE, SRC_MD} src_e;

    logic [1:0]  vld_q, vld_d, live_q, live_d;
    logic [4:0]  rd_q [2];
    logic [4:0]  rd_d [2];
    logic [31:0] data_q [2];
    logic [31:0] data_d [2];
    logic [3:0]  cnt_q, cnt_d;

    logic        pipe_we, pw, head_live, acc_keep, pop;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic [1:0]  occ;
    src_e        src;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pipe_we   = 1'b0;
        pipe_rd   = ir_in[26:22];
        pipe_data = o_in;
        case (ir_in[31:27])
            5'b00000, 5'b00101: pipe_we = 1'b1;
            5'b01000: begin
                pipe_we   = 1'b1;
                pipe_data = d_in;
            end
            5'b00011: begin
                pipe_we = 1'b1;
                pipe_rd = 5'd31;
            end
            5'b10101: begin
                pipe_we   = 1'b1;
                pipe_rd   = 5'd30;
                pipe_data = {5'b0, ir_in[26:0]};
            end
            default: ;
        endcase
        pw = pipe_we && (pipe_rd != 5'd0);
    end

    // In-order FIFO: an entry in slot 1 always implies an entry in slot 0.
    assign occ       = vld_q[1] ? 2'd2 : (vld_q[0] ? 2'd1 : 2'd0);
    assign head_live = vld_q[0] && live_q[0];
    assign md_ready  = clear && (occ != 2'd2);
    assign acc_keep  = md_valid && md_ready && (md_rd != 5'd0);
    assign stall_out = clear && (cnt_q >= 4'(STARVE_LIMIT));

    always_comb begin
        src = SRC_NONE;
        if (clear) begin
            if (stall_out && head_live)  src = SRC_HEAD;
            else if (pw && !stall_out)   src = SRC_PIPE;
            else if (head_live)          src = SRC_HEAD;
            else if (occ == 2'd0 && acc_keep) src = SRC_MD;
        end
        pop = vld_q[0] && (src == SRC_HEAD || !live_q[0]);

        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        case (src)
            SRC_HEAD: begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = rd_q[0];
                data_writeReg    = data_q[0];
            end
            SRC_PIPE: begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = pipe_rd;
                data_writeReg    = pipe_data;
            end
            SRC_MD: begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = md_rd;
                data_writeReg    = md_result;
            end
            default: ;
        endcase
    end

    always_comb begin
        vld_d  = vld_q;
        live_d = live_q;
        rd_d   = rd_q;
        data_d = data_q;

        // A pipeline write supersedes older buffered results to the same register.
        if (src == SRC_PIPE) begin
            for (int i = 0; i < 2; i++) begin
                if (vld_q[i] && live_q[i] && rd_q[i] == pipe_rd) live_d[i] = 1'b0;
            end
        end

        if (pop) begin
            vld_d[0]  = vld_d[1];
            live_d[0] = live_d[1];
            rd_d[0]   = rd_q[1];
            data_d[0] = data_q[1];
            vld_d[1]  = 1'b0;
            live_d[1] = 1'b0;
        end

        if (acc_keep && src != SRC_MD) begin
            if (!vld_d[0]) begin
                vld_d[0]  = 1'b1;
                live_d[0] = 1'b1;
                rd_d[0]   = md_rd;
                data_d[0] = md_result;
            end else begin
                vld_d[1]  = 1'b1;
                live_d[1] = 1'b1;
                rd_d[1]   = md_rd;
                data_d[1] = md_result;
            end
        end

        cnt_d = cnt_q;
        if (occ == 2'd0 || pop) cnt_d = 4'd0;
        else if (head_live)     cnt_d = cnt_q + 4'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!clear) begin
            vld_q  <= '0;
            live_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            live_q <= live_d;
            cnt_q  <= cnt_d;
        end
    end

    // NOTE: buffer payload is not reset; it is never observed unless its valid bit is set.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    assign pend_count = clear ? (2'(head_live) + 2'(vld_q[1] && live_q[1])) : 2'd0;
    assign pend_rd0   = (clear && head_live) ? rd_q[0] : 5'd0;
    assign pend_rd1   = (clear && vld_q[1] && live_q[1]) ? rd_q[1] : 5'd0;

endmodule
